// File: rtl/fwd_hazard_scoreboard_pkg.sv
`default_nettype none
// ============================================================================
// Module   : lc3b_types (package)
// Purpose  : Shared types for the LC-3b forwarding / hazard scoreboard.
//            fwd_sel_t    - EX operand forward select encoding
//            shadow_tag_t - per-stage destination tag {vld, wr, load, dest}
//            tag_match()  - producer/consumer match for one source operand
// Revision : 1.0 - initial release
// ============================================================================
package lc3b_types;

  localparam int LC3B_REG_W = 3;

  // NONE: regfile, MEM: EX/MEM ALU result, WB: MEM/WB value (incl. load data),
  // WBL: value written last cycle, held in the datapath late register.
  typedef enum logic [1:0] {
    FWD_NONE = 2'b00,
    FWD_MEM  = 2'b01,
    FWD_WB   = 2'b10,
    FWD_WBL  = 2'b11
  } fwd_sel_t;

  typedef struct packed {
    logic                  vld;
    logic                  wr;
    logic                  load;
    logic [LC3B_REG_W-1:0] dest;
  } shadow_tag_t;

  // Register 0 is an ordinary register here; no zero-register exception.
  function automatic logic tag_match(input shadow_tag_t           tag,
                                     input logic                  use_src,
                                     input logic [LC3B_REG_W-1:0] src);
    return tag.vld && tag.wr && use_src && (tag.dest == src);
  endfunction

endpackage
`default_nettype wire

// File: rtl/fwd_hazard_scoreboard_if.sv
`default_nettype none
// ============================================================================
// Module   : fwd_hazard_scoreboard_if
// Purpose  : Bundle of ID-side request, pipeline control and scoreboard
//            results exchanged between the ID/EX datapath and the scoreboard.
// Modports : master - datapath side (drives id_*, mem_wait, flush)
//            slave  - scoreboard side (drives stall, ex_fwd_sel, valids, cnts)
// Revision : 1.0 - initial release
// ============================================================================
interface fwd_hazard_scoreboard_if #(
  parameter int REG_W   = 3,
  parameter int NUM_SRC = 2,
  parameter int CNT_W   = 16
);
  logic                     id_valid;
  logic                     id_regfile_write;
  logic                     id_load_inst;
  logic [REG_W-1:0]         id_dest;
  logic [NUM_SRC-1:0]       id_uses_src;
  logic [NUM_SRC*REG_W-1:0] id_src;
  logic                     mem_wait;
  logic                     flush;
  logic                     stall;
  logic [2*NUM_SRC-1:0]     ex_fwd_sel;
  logic                     ex_valid;
  logic                     mem_valid;
  logic                     wb_valid;
  logic [CNT_W-1:0]         load_use_cnt;
  logic [CNT_W-1:0]         mem_wait_cnt;

  modport master (
    output id_valid, id_regfile_write, id_load_inst, id_dest, id_uses_src,
           id_src, mem_wait, flush,
    input  stall, ex_fwd_sel, ex_valid, mem_valid, wb_valid, load_use_cnt,
           mem_wait_cnt
  );

  modport slave (
    input  id_valid, id_regfile_write, id_load_inst, id_dest, id_uses_src,
           id_src, mem_wait, flush,
    output stall, ex_fwd_sel, ex_valid, mem_valid, wb_valid, load_use_cnt,
           mem_wait_cnt
  );
endinterface
`default_nettype wire

// File: rtl/fwd_hazard_scoreboard_fwd_src_select.sv
`default_nettype none
// ============================================================================
// Module   : fwd_src_select
// Purpose  : Per-source forward resolution against the shadow EX/MEM/WB tags.
//            Youngest non-load producer wins (EX->MEM, MEM->WB, WB->WBL).
// Ports    : ex_tag/mem_tag/wb_tag - pre-advance shadow stage tags
//            use_src, src          - consumer source use flag and index
//            sel                   - resolved fwd_sel_t
//            load_hit              - source depends on a load sitting in EX
// Revision : 1.0 - initial release
// ============================================================================
module fwd_src_select
  import lc3b_types::*;
(
  input  shadow_tag_t           ex_tag,
  input  shadow_tag_t           mem_tag,
  input  shadow_tag_t           wb_tag,
  input  logic                  use_src,
  input  logic [LC3B_REG_W-1:0] src,
  output fwd_sel_t              sel,
  output logic                  load_hit
);

  logic ex_hit;
  logic mem_hit;
  logic wb_hit;
  logic unused_load_bits;

  assign ex_hit   = tag_match(ex_tag,  use_src, src);
  assign mem_hit  = tag_match(mem_tag, use_src, src);
  assign wb_hit   = tag_match(wb_tag,  use_src, src);
  assign load_hit = ex_hit && ex_tag.load;

  // By MEM/WB a load's data is available, so only the EX load flag matters.
  assign unused_load_bits = mem_tag.load ^ wb_tag.load;

  always_comb begin
    sel = FWD_NONE;
    if (ex_hit && !ex_tag.load) begin
      sel = FWD_MEM;
    end else if (mem_hit) begin
      sel = FWD_WB;
    end else if (wb_hit) begin
      sel = FWD_WBL;
    end
  end

endmodule
`default_nettype wire

// File: rtl/fwd_hazard_scoreboard.sv
`default_nettype none
// ============================================================================
// Module   : fwd_hazard_scoreboard
// Purpose  : LC-3b forwarding and hazard unit. Tracks destination tags in a
//            shadow EX/MEM/WB pipeline, resolves forwarding at issue and
//            presents registered per-source selects while the instruction is
//            in EX. Generates load-use stalls, freezes on mem_wait, and kills
//            the instruction entering EX on flush.
// Ports    : clk, rst_n (async active-low)
//            bus (slave) - id_* request, mem_wait, flush in;
//                          stall, ex_fwd_sel, stage valids, counters out
// Options  : FWD_PERF_CNT_EN - enables saturating load_use_cnt/mem_wait_cnt;
//            when undefined both counters read 0 and have no flops.
// Revision : 1.0 - initial release
// ============================================================================
module fwd_hazard_scoreboard
  import lc3b_types::*;
#(
  parameter int REG_W   = 3,   // must equal LC3B_REG_W (shadow tag width)
  parameter int NUM_SRC = 2,
  parameter int CNT_W   = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  fwd_hazard_scoreboard_if.slave  bus
);

  shadow_tag_t          ex_q,  ex_d;
  shadow_tag_t          mem_q, mem_d;
  shadow_tag_t          wb_q,  wb_d;
  logic [2*NUM_SRC-1:0] fwd_sel_q, fwd_sel_d;

  fwd_sel_t             src_sel [NUM_SRC];
  logic [NUM_SRC-1:0]   src_load_hit;
  logic                 load_use;
  logic                 advance;
  logic                 issue;

  generate
    for (genvar s = 0; s < NUM_SRC; s++) begin : g_src
      fwd_src_select u_fwd_src_select (
        .ex_tag   (ex_q),
        .mem_tag  (mem_q),
        .wb_tag   (wb_q),
        .use_src  (bus.id_uses_src[s]),
        .src      (bus.id_src[s*REG_W +: REG_W]),
        .sel      (src_sel[s]),
        .load_hit (src_load_hit[s])
      );
    end
  endgenerate

  assign load_use = bus.id_valid && (|src_load_hit);
  assign advance  = !bus.mem_wait;
  assign issue    = bus.id_valid && !load_use && !bus.flush;

  always_comb begin
    ex_d      = ex_q;
    mem_d     = mem_q;
    wb_d      = wb_q;
    fwd_sel_d = fwd_sel_q;
    if (advance) begin
      wb_d  = mem_q;
      mem_d = ex_q;
      ex_d  = '{vld: issue, wr: bus.id_regfile_write,
                load: bus.id_load_inst, dest: bus.id_dest};
      for (int s = 0; s < NUM_SRC; s++) begin
        fwd_sel_d[2*s +: 2] = issue ? src_sel[s] : FWD_NONE;
      end
    end else if (bus.flush) begin
      // Frozen pipeline, but the instruction entering EX is still killed.
      ex_d.vld  = 1'b0;
      fwd_sel_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_q      <= '0;
      mem_q     <= '0;
      wb_q      <= '0;
      fwd_sel_q <= '0;
    end else begin
      ex_q      <= ex_d;
      mem_q     <= mem_d;
      wb_q      <= wb_d;
      fwd_sel_q <= fwd_sel_d;
    end
  end

  assign bus.stall      = load_use || bus.mem_wait;
  assign bus.ex_fwd_sel = fwd_sel_q;
  assign bus.ex_valid   = ex_q.vld;
  assign bus.mem_valid  = mem_q.vld;
  assign bus.wb_valid   = wb_q.vld;

`ifdef FWD_PERF_CNT_EN
  logic [CNT_W-1:0] load_use_cnt_q, load_use_cnt_d;
  logic [CNT_W-1:0] mem_wait_cnt_q, mem_wait_cnt_d;

  // Both counters saturate at all-ones.
  always_comb begin
    load_use_cnt_d = load_use_cnt_q;
    mem_wait_cnt_d = mem_wait_cnt_q;
    if (load_use && advance && (load_use_cnt_q != '1)) begin
      load_use_cnt_d = load_use_cnt_q + 1'b1;
    end
    if (bus.mem_wait && (mem_wait_cnt_q != '1)) begin
      mem_wait_cnt_d = mem_wait_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      load_use_cnt_q <= '0;
      mem_wait_cnt_q <= '0;
    end else begin
      load_use_cnt_q <= load_use_cnt_d;
      mem_wait_cnt_q <= mem_wait_cnt_d;
    end
  end

  assign bus.load_use_cnt = load_use_cnt_q;
  assign bus.mem_wait_cnt = mem_wait_cnt_q;
`else
  assign bus.load_use_cnt = '0;
  assign bus.mem_wait_cnt = '0;
`endif

endmodule
`default_nettype wire

// File: doc/fwd_hazard_scoreboard.md
Name: fwd_hazard_scoreboard

Overview:
- Parametrised forwarding and hazard unit for the pipelined LC-3b datapath.
- Keeps its own shadow pipeline of destination tags (EX/MEM/WB) and resolves forwarding at issue time, delivering registered per-source forward selects while the instruction is in EX.
- Generates load-use stalls, honours variable-latency memory waits, and supports flushes.
- Sits beside the ID/EX boundary and drives the EX operand muxes and the ID/IF stall logic.

Parameters:
- REG_W, 3, register index width (lc3b_reg).
- NUM_SRC, 2, source operands per instruction.
- CNT_W, 16, width of performance counters (used only with the optional feature).

Ports:
- clk  in  1  pipeline clock.
- rst_n  in  1  asynchronous active-low reset.
- id_valid  in  1  instruction in ID issues this cycle if not stalled.
- id_regfile_write  in  1  ID instruction writes a register.
- id_load_inst  in  1  ID instruction is a load (data available end of MEM).
- id_dest  in  REG_W  ID destination register.
- id_uses_src  in  NUM_SRC  per-source use flags.
- id_src  in  NUM_SRC*REG_W  packed source indices; source i is bits [i*REG_W +: REG_W].
- mem_wait  in  1  memory not ready; freeze the whole pipeline.
- flush  in  1  kill the instruction entering EX (taken branch).
- stall  out  1  hold IF/ID; insert a bubble into EX.
- ex_fwd_sel  out  2*NUM_SRC  registered forward select per source, valid while the instruction is in EX.
- ex_valid, mem_valid, wb_valid  out  1 each  shadow-stage occupancy.
- load_use_cnt, mem_wait_cnt  out  CNT_W each  performance counters.

Behaviour:
- Shadow stage registers ex_q, mem_q, wb_q, each holding {vld, wr, load, dest}.
- Reset value of every output is 0: stage valids 0, ex_fwd_sel all FWD_NONE, counters 0, stall 0.
- Forward encoding (fwd_sel_t):
  - 00 NONE: use the regfile.
  - 01 MEM: EX/MEM ALU result.
  - 10 WB: MEM/WB value, including load data.
  - 11 WBL: value written last cycle, held in the datapath's one-entry late register.
- match(stage, s) = stage.vld && stage.wr && id_uses_src[s] && stage.dest == id_src[s].
- load_use = id_valid && OR over s of (match(ex_q, s) && ex_q.load).
- stall = load_use || mem_wait. This is combinational, zero latency.
- advance = !mem_wait.
- When advance:
  - wb_q <= mem_q and mem_q <= ex_q.
  - ex_q <= id fields with vld = id_valid && !load_use && !flush. Otherwise the bubble has vld = 0.
  - For each s, ex_fwd_sel[s] <= the youngest match, evaluated against the pre-advance stages:
    - ex_q non-load match gives MEM.
    - Else mem_q match gives WB.
    - Else wb_q match gives WBL.
    - Else NONE.
  - A bubble loads NONE into ex_fwd_sel.
- When mem_wait: all stage registers and ex_fwd_sel hold.
  - flush still clears ex_q.vld and ex_fwd_sel.
  - flush has priority over hold for EX only.
- Load-use costs exactly 1 bubble. Next cycle the load is in mem_q, so the reissued consumer gets WB.
- Both sources matching different stages select independently.
- Same source matched in several stages: the youngest wins.
- id_regfile_write = 0 instructions never match as producers.
- Register 0 is an ordinary register (no zero-register exception).
- rst_n asserted mid-operation clears all state immediately. The first cycle after release behaves as an empty pipeline.

Optional Feature:
- Macro FWD_PERF_CNT_EN.
- Defined:
  - load_use_cnt increments each cycle load_use && !mem_wait.
  - mem_wait_cnt increments each cycle mem_wait.
  - Both saturate at all-ones and reset to 0.
- Undefined: both ports tied to 0 and no counter flops are synthesised.

Decomposition:
- lc3b_types package gets typedef enum logic [1:0] fwd_sel_t {FWD_NONE, FWD_MEM, FWD_WB, FWD_WBL}.
- lc3b_types package also gets the packed struct shadow_tag_t {vld, wr, load, dest}.
- One sub-module, fwd_src_select: given the three tags plus one source index and use flag, returns fwd_sel_t and a load-hit flag.
- fwd_src_select is instantiated NUM_SRC times via generate.

Test Plan:
- ADD R1 then ADD R2,R1,R3 on consecutive cycles -> second in EX has ex_fwd_sel[0]=MEM, stall never asserted.
- LDR R4 then ADD R5,R4,R4 -> stall=1 for exactly 1 cycle, ex_valid=0 for the bubble, then ex_fwd_sel[0]=ex_fwd_sel[1]=WB.
- Producers R1 at distance 1, 2 and 3 to sources (R1,R1) -> MEM wins; remove the nearest producer -> WB; remove that too -> WBL.
- mem_wait high 3 cycles during a load-use -> stall high throughout, stage registers and ex_fwd_sel frozen, mem_wait_cnt=3 with FWD_PERF_CNT_EN.
- flush with id_valid=1 and a matching producer -> ex_valid=0, ex_fwd_sel=NONE next cycle; flush during mem_wait clears EX only.
- rst_n pulsed low mid-stream -> all outputs 0 asynchronously; first post-reset consumer gets NONE.
